// File: rtl/vga_scanout_controller_pkg.sv
// Shared types and default 800x600 raster constants for the VGA scan-out path.
package vga_scanout_controller_pkg;

    typedef logic [3:0] VgaColorNumber_t;

    localparam int VGA_CNT_W = 12;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] hcnt;
        logic [VGA_CNT_W-1:0] vcnt;
        logic                 active;
        logic                 hs;
        logic                 vs;
    } VgaTiming_t;

    typedef enum logic {
        TG_HOLD = 1'b0,
        TG_RUN  = 1'b1
    } tg_state_t;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FP     = 56;
    localparam int VGA_H_SYNC   = 120;
    localparam int VGA_H_BP     = 64;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FP     = 37;
    localparam int VGA_V_SYNC   = 6;
    localparam int VGA_V_BP     = 23;

    // True when cnt lies in [lo, lo+len).
    function automatic logic in_window(input logic [VGA_CNT_W-1:0] cnt, input int lo, input int len);
        int c;
        c = int'(cnt);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/vga_scanout_controller_timing_gen.sv
// Raster counters with sync/active decode; exposes next-cycle decode so the top can register fetches.
// Latency: frame_start is registered and aligned with the counters (stage 0). Optional irq tap: VGA_VBLANK_IRQ_EN.
// Backpressure: none, free-running once out of reset.
module vga_scanout_controller_timing_gen
    import vga_scanout_controller_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic rst,
    output logic frame_start,
    output logic frame_start_nxt,
    output logic nxt_active,
    output logic nxt_fetch,
    output logic nxt_hs,
    output logic nxt_vs
`ifdef VGA_VBLANK_IRQ_EN
    ,
    output logic nxt_last
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    tg_state_t              state;
    tg_state_t              state_nxt;
    logic [VGA_CNT_W-1:0]   h_cnt;
    logic [VGA_CNT_W-1:0]   v_cnt;
    VgaTiming_t             nxt;

    // The first cycle out of reset holds h=0,v=0 so that position gets a real frame_start.
    always_comb begin
        state_nxt = TG_RUN;
        nxt       = '0;
        if (state == TG_RUN) begin
            if (int'(h_cnt) == H_TOTAL - 1) begin
                nxt.hcnt = '0;
                nxt.vcnt = (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + VGA_CNT_W'(1);
            end else begin
                nxt.hcnt = h_cnt + VGA_CNT_W'(1);
                nxt.vcnt = v_cnt;
            end
        end
        nxt.active = in_window(nxt.hcnt, 0, H_ACTIVE) && in_window(nxt.vcnt, 0, V_ACTIVE);
        nxt.hs     = in_window(nxt.hcnt, H_ACTIVE + H_FP, H_SYNC);
        nxt.vs     = in_window(nxt.vcnt, V_ACTIVE + V_FP, V_SYNC);
    end

    assign frame_start_nxt = (nxt.hcnt == '0) && (nxt.vcnt == '0);
    assign nxt_active      = nxt.active;
    assign nxt_fetch       = nxt.active && (nxt.hcnt[2:0] == 3'd0);
    assign nxt_hs          = nxt.hs;
    assign nxt_vs          = nxt.vs;
`ifdef VGA_VBLANK_IRQ_EN
    assign nxt_last        = nxt.active && (int'(nxt.hcnt) == H_ACTIVE - 1)
                             && (int'(nxt.vcnt) == V_ACTIVE - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TG_HOLD;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            h_cnt       <= nxt.hcnt;
            v_cnt       <= nxt.vcnt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: rtl/vga_scanout_controller.sv
// VGA scan-out: raster timing, framebuffer word fetch, nibble unpack to palette index. Optional vblank irq: VGA_VBLANK_IRQ_EN.
// Latency: sync/de/color_number lag stage-0 counters by RD_LATENCY+1 cycles; fb_rd_en is aligned with stage 0.
// Backpressure: none; the framebuffer must return data exactly RD_LATENCY cycles after each strobe.
module vga_scanout_controller
    import vga_scanout_controller_pkg::*;
#(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter logic HSYNC_POL  = 1'b1,
    parameter logic VSYNC_POL  = 1'b1,
    parameter int   RD_LATENCY = 2,
    parameter int   ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [31:0]       fb_rd_data,
    output VgaColorNumber_t   color_number,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
`ifdef VGA_VBLANK_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_ack
`endif
);

    localparam int LAT = RD_LATENCY + 1;

    logic                  fs_nxt;
    logic                  nxt_active;
    logic                  nxt_fetch;
    logic                  nxt_hs;
    logic                  nxt_vs;
    logic                  enable_q;
    logic [ADDR_W-1:0]     ptr;
    logic                  en_eff;
    logic [ADDR_W-1:0]     ptr_eff;
    logic                  fetch_nxt;
    logic [RD_LATENCY-1:0] rd_dly;
    logic [27:0]           pix_sr;
    logic [LAT:0]          de_pipe;
    logic [LAT:0]          hs_pipe;
    logic [LAT:0]          vs_pipe;
    logic [LAT-1:0]        pix_pipe;

`ifdef VGA_VBLANK_IRQ_EN
    logic                  nxt_last;
    logic [LAT:0]          last_pipe;
`endif

    vga_scanout_controller_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .frame_start_nxt (fs_nxt),
        .nxt_active      (nxt_active),
        .nxt_fetch       (nxt_fetch),
        .nxt_hs          (nxt_hs),
        .nxt_vs          (nxt_vs)
`ifdef VGA_VBLANK_IRQ_EN
        ,
        .nxt_last        (nxt_last)
`endif
    );

    // Frame-start values are latched on the edge entering h=0,v=0, so that
    // cycle's fetch already uses the new enable and base.
    always_comb begin
        en_eff    = fs_nxt ? enable  : enable_q;
        ptr_eff   = fs_nxt ? fb_base : ptr;
        fetch_nxt = nxt_fetch && en_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= 1'b0;
            ptr        <= '0;
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
        end else begin
            enable_q <= en_eff;
            fb_rd_en <= fetch_nxt;
            if (fetch_nxt) begin
                fb_rd_addr <= ptr_eff;
                ptr        <= ptr_eff + ADDR_W'(1);
            end else begin
                ptr        <= ptr_eff;
            end
        end
    end

    // Word arrives in the cycle before its first pixel is shown; nibble 0 goes
    // straight to the output and the rest queue in the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dly       <= '0;
            pix_sr       <= '0;
            color_number <= '0;
            de_pipe      <= '0;
            pix_pipe     <= '0;
            hs_pipe      <= {(LAT+1){~HSYNC_POL}};
            vs_pipe      <= {(LAT+1){~VSYNC_POL}};
        end else begin
            rd_dly[0] <= fb_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_dly[i] <= rd_dly[i-1];
            end

            de_pipe[0]  <= nxt_active;
            pix_pipe[0] <= nxt_active && en_eff;
            hs_pipe[0]  <= nxt_hs ? HSYNC_POL : ~HSYNC_POL;
            vs_pipe[0]  <= nxt_vs ? VSYNC_POL : ~VSYNC_POL;
            for (int i = 1; i <= LAT; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            for (int i = 1; i < LAT; i++) begin
                pix_pipe[i] <= pix_pipe[i-1];
            end

            if (rd_dly[RD_LATENCY-1]) begin
                pix_sr <= fb_rd_data[31:4];
            end else begin
                pix_sr <= {4'd0, pix_sr[27:4]};
            end

            if (!pix_pipe[LAT-1]) begin
                color_number <= '0;
            end else if (rd_dly[RD_LATENCY-1]) begin
                color_number <= fb_rd_data[3:0];
            end else begin
                color_number <= pix_sr[3:0];
            end
        end
    end

    assign de    = de_pipe[LAT];
    assign hsync = hs_pipe[LAT];
    assign vsync = vs_pipe[LAT];

`ifdef VGA_VBLANK_IRQ_EN
    // last_pipe[LAT] marks the final visible pixel at the output; de drops on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pipe <= '0;
            irq       <= 1'b0;
        end else begin
            last_pipe[0] <= nxt_last;
            for (int i = 1; i <= LAT; i++) begin
                last_pipe[i] <= last_pipe[i-1];
            end
            if (irq_ack) begin
                irq <= 1'b0;
            end else if (last_pipe[LAT]) begin
                irq <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/vga_scanout_controller.md
Name: vga_scanout_controller

Overview:
- Sequences pixel scan-out for the VGA path: generates raster timing, fetches 4-bit palette indices from framebuffer BRAM, and drives VgaColorNumber_t into the palette mapper.
- Sits between the framebuffer read port and the color mapper / VGA pins.
- All outputs registered and delay-matched so sync, DE and pixel index stay aligned.

Parameters:
- H_ACTIVE, 800, visible pixels per line; must be a multiple of 8.
- H_FP, 56, horizontal front porch (pixels).
- H_SYNC, 120, hsync width.
- H_BP, 64, horizontal back porch.
- V_ACTIVE, 600, visible lines.
- V_FP, 37, vertical front porch (lines).
- V_SYNC, 6, vsync width.
- V_BP, 23, vertical back porch.
- HSYNC_POL, 1, active level of hsync.
- VSYNC_POL, 1, active level of vsync.
- RD_LATENCY, 2, fixed framebuffer read latency in cycles (1..4).
- ADDR_W, 17, framebuffer word-address width.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan-out enable; sampled at frame start.
- fb_base  in  ADDR_W  framebuffer base word address; sampled at frame start.
- fb_rd_en  out  1  read strobe, one cycle per word.
- fb_rd_addr  out  ADDR_W  word address.
- fb_rd_data  in  32  read data, valid exactly RD_LATENCY cycles after fb_rd_en.
- color_number  out  VgaColorNumber_t  palette index to color_mapper.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- de  out  1  display enable (active video).
- frame_start  out  1  one-cycle pulse at h=0, v=0 (stage-0 timing).

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H_*). v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Stage-0 timing: active = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE). Sync is active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), same rule for vsync.
- Frame start (h=0, v=0) latches enable_q and base_q, and resets the linear word pointer to base_q.
- Fetch: when active && h_cnt[2:0]==0 && enable_q, fb_rd_en=1 and fb_rd_addr=pointer; the pointer then increments. The pointer wraps modulo 2^ADDR_W.
- Unpack: a 32-bit word arriving RD_LATENCY cycles later loads an 8-nibble shift register. The pixel at h offset k = bits [4k+3:4k] (LSB first). Shift 4 bits per cycle.
- Output latency L = RD_LATENCY+1 cycles from stage-0 counters to hsync/vsync/de/color_number. Delay-line sync/DE accordingly.
- color_number is 0 whenever de=0 or enable_q=0. When disabled, no fetches occur but timing continues.
- enable/fb_base changes mid-frame take effect only at the next frame start.
- Reset values: counters 0, pointer 0, enable_q 0, fb_rd_en 0, fb_rd_addr 0, de 0, color_number 0, frame_start 0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, delay lines cleared.
- Reset mid-frame: all state returns to reset values next cycle. The first cycle after rst deasserts is h=0, v=0 (frame_start pulses).
- No fetch is ever issued during blanking. Exactly H_ACTIVE/8 fetches per active line.

Optional Feature:
- VGA_VBLANK_IRQ_EN adds ports irq (out, 1) and irq_ack (in, 1).
- irq is set on the cycle the output-stage de falls after the last active line. It is held until irq_ack=1; ack wins over a simultaneous set. Reset value 0.
- Without the macro, the ports and logic are absent.

Decomposition:
- common_defs.svh already has VgaColorNumber_t. Add there: VgaTiming_t struct (hcnt, vcnt, active, hs, vs) and the default 800x600 timing constants.
- Natural sub-module: vga_timing_gen (counters, sync/active decode, frame_start). The fetch/unpack/delay logic stays in the top.

Test Plan:
- Timing: small params (H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP/V_SYNC/V_BP=1), enable=0 -> line 24 cycles, frame 7 lines; hsync width 3, vsync 1 line; de high 16 cycles/line for 4 lines; color_number always 0; fb_rd_en never 1.
- Fetch/unpack: enable=1, fb_base=0x100, memory word n = {8{n[3:0]}} -> fetches at addresses 0x100..0x107 (2/line); de-aligned color_number equals word index nibble; first pixel appears exactly L=3 cycles after h=0 of line 0.
- Pixel order: word 0x76543210 at address base -> color_number sequence 0,1,2,...,7 on consecutive de cycles.
- Mid-frame changes: toggle enable 1->0 and fb_base at line 2 -> rest of frame unchanged; next frame has no fetches and output 0.
- Reset mid-line: assert rst at h=5, v=1 for 1 cycle -> next cycle all outputs at reset values, then frame_start pulse, fetch at base_q from new enable/fb_base.
- VGA_VBLANK_IRQ_EN: irq rises the cycle after the last de of line 3; irq_ack on that same cycle -> irq stays 0; otherwise held until ack.
